bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1024, is the grant-hold watchdog limit in clk cycles; range 0..65535; 0 disables the watchdog.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 transaction_begin_a  input  1  CPU A request level, held high until A sees transaction_end_y.
REQ-005 transaction_begin_b  input  1  CPU B request level, same rules as A.
REQ-006 transaction_end_y  input  1  one-cycle completion pulse from the downstream target, routed through the switch.
REQ-007 clear_error  input  1  synchronous clear of timeout_status.
REQ-008 select  output  1  switch port select, registered; 0 = A, 1 = B.
REQ-009 begin_gated_a  output  1  = transaction_begin_a AND grant_a, combinational; feeds switch transaction_begin_a.
REQ-010 begin_gated_b  output  1  = transaction_begin_b AND grant_b, combinational; feeds switch transaction_begin_b.
REQ-011 grant_a, grant_b  output  1 each  registered, one-hot or zero.
REQ-012 busy  output  1  high in GRANT_A, GRANT_B and RELEASE.
REQ-013 timeout_pulse  output  1  one-cycle pulse when the watchdog fires.
REQ-014 timeout_status  output  1  sticky watchdog flag.

Function
REQ-015 States: IDLE, GRANT_A, GRANT_B, RELEASE; encoded registered FSM.
REQ-016 IDLE, only begin_a high -> GRANT_A; only begin_b high -> GRANT_B; neither -> stay IDLE.
REQ-017 IDLE, both high -> grant the port not served last (last_grant register); then update last_grant.
REQ-018 Grant latency: request sampled high at edge N in IDLE -> grant_x and select valid after edge N (one cycle).
REQ-019 select updates only on the IDLE->GRANT transition; it holds its value in all other states.
REQ-020 GRANT_x: transaction_end_y sampled high -> RELEASE; grant_x low after that edge.
REQ-021 GRANT_x: begin_x dropping without end -> stay in GRANT_x; only end or timeout exits.
REQ-022 RELEASE lasts exactly one cycle; requests are ignored; then IDLE unconditionally.
REQ-023 A requester deasserts begin at least one cycle after end; a begin still high in IDLE counts as a new request.
REQ-024 Watchdog: 16-bit counter, cleared on entry to GRANT_x, increments each cycle in GRANT_x, saturates; never counts in IDLE or RELEASE.
REQ-025 TIMEOUT>0, counter reaching TIMEOUT-1 without end -> timeout_pulse high for one cycle, timeout_status set, state -> RELEASE.
REQ-026 end and timeout in the same cycle: end wins; no pulse; status unchanged.
REQ-027 clear_error and a new timeout in the same cycle: set wins.
REQ-028 transaction_end_y in IDLE or RELEASE is ignored.

Reset
REQ-029 rst_n low immediately forces: IDLE; select=0; grant_a=grant_b=0; busy=0; timeout_pulse=0; timeout_status=0; counter=0; last_grant=B, so A wins the first tie.
REQ-030 Reset mid-grant drops grants and gated begins at once; no pulse is generated.

Verification
REQ-031 Reset release, begin_a=1 at cycle 0 -> grant_a=1, select=0 at cycle 1; end at cycle 5 -> RELEASE at 6, IDLE at 7.
REQ-032 begin_a=begin_b=1 together from IDLE, held continuously, with end after each grant -> grants alternate A,B,A,B and select alternates 0,1,0,1.
REQ-033 TIMEOUT=8, grant B, no end -> timeout_pulse at 8th grant cycle, timeout_status=1, grant_b=0 next; clear_error -> status=0.
REQ-034 TIMEOUT=8, end on the 8th grant cycle -> no pulse, normal RELEASE.
REQ-035 begin_b rises during a GRANT_A -> begin_gated_b stays 0 and select stays 0 until GRANT_B is entered.
REQ-036 rst_n asserted in GRANT_B -> grant_b=0, select=0 asynchronously; after release, the first tie goes to A.

Source files
------------

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Two-master arbiter in front of a 2:1 transaction switch. CPU A and CPU B
// raise a request level; the arbiter grants one of them, steers the switch
// with `select`, and gates each master's begin strobe so only the granted
// master reaches the switch. A grant ends on the downstream completion pulse
// or when the grant-hold watchdog expires; a one-cycle RELEASE state follows
// every grant before a new arbitration.
//
// Parameters
//   TIMEOUT              watchdog limit in clk cycles (0..65535, 0 = disabled)
//
// Ports
//   clk                  clock, rising edge
//   rst_n                asynchronous active-low reset
//   transaction_begin_a  CPU A request level
//   transaction_begin_b  CPU B request level
//   transaction_end_y    one-cycle completion pulse from the target
//   clear_error          synchronous clear of timeout_status
//   select               switch port select (0 = A, 1 = B), registered
//   begin_gated_a/_b     request AND grant, combinational, to the switch
//   grant_a/_b           registered grants, one-hot or zero
//   busy                 high while granting or releasing
//   timeout_pulse        one-cycle pulse in the grant cycle the watchdog fires
//   timeout_status       sticky watchdog flag
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic transaction_begin_a,
  input  logic transaction_begin_b,
  input  logic transaction_end_y,
  input  logic clear_error,
  output logic select,
  output logic begin_gated_a,
  output logic begin_gated_b,
  output logic grant_a,
  output logic grant_b,
  output logic busy,
  output logic timeout_pulse,
  output logic timeout_status
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_A = 2'd1,
    ST_GRANT_B = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // The watchdog fires in the grant cycle whose counter value is TIMEOUT-1,
  // i.e. the TIMEOUT-th cycle of the grant.
  localparam bit          WD_EN      = (TIMEOUT != 0);
  localparam int unsigned WD_LIMIT_I = (TIMEOUT == 0) ? 0 : (TIMEOUT - 1);
  localparam logic [15:0] WD_LIMIT   = WD_LIMIT_I[15:0];
  localparam logic [15:0] WD_MAX     = 16'hFFFF;

  state_t      state_q, state_d;
  logic        select_q, select_d;
  logic        grant_a_q, grant_a_d;
  logic        grant_b_q, grant_b_d;
  logic        busy_q, busy_d;
  logic        status_q, status_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        last_grant_q, last_grant_d;  // 1 = B was served last
  logic        in_grant;
  logic        wd_fire;

  assign in_grant = (state_q == ST_GRANT_A) || (state_q == ST_GRANT_B);

  // A completion in the same cycle as the watchdog limit takes priority, so
  // the watchdog only fires when no end pulse is present.
  assign wd_fire = WD_EN && in_grant && (wd_cnt_q == WD_LIMIT) && !transaction_end_y;

  always_comb begin
    state_d      = state_q;
    select_d     = select_q;
    wd_cnt_d     = wd_cnt_q;
    last_grant_d = last_grant_q;
    status_d     = status_q;

    case (state_q)
      ST_IDLE: begin
        // A wins when alone, or on a tie when B was served last.
        if (transaction_begin_a && (!transaction_begin_b || last_grant_q)) begin
          state_d      = ST_GRANT_A;
          select_d     = 1'b0;
          last_grant_d = 1'b0;
          wd_cnt_d     = 16'd0;
        end else if (transaction_begin_b) begin
          state_d      = ST_GRANT_B;
          select_d     = 1'b1;
          last_grant_d = 1'b1;
          wd_cnt_d     = 16'd0;
        end
      end
      ST_GRANT_A, ST_GRANT_B: begin
        // Only completion or watchdog leaves a grant; a dropped request
        // does not.
        if (transaction_end_y || wd_fire) begin
          state_d = ST_RELEASE;
        end else if (wd_cnt_q != WD_MAX) begin
          wd_cnt_d = wd_cnt_q + 16'd1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Setting the flag beats a simultaneous clear.
    if (wd_fire) begin
      status_d = 1'b1;
    end else if (clear_error) begin
      status_d = 1'b0;
    end

    grant_a_d = (state_d == ST_GRANT_A);
    grant_b_d = (state_d == ST_GRANT_B);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      select_q     <= 1'b0;
      grant_a_q    <= 1'b0;
      grant_b_q    <= 1'b0;
      busy_q       <= 1'b0;
      status_q     <= 1'b0;
      wd_cnt_q     <= 16'd0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      select_q     <= select_d;
      grant_a_q    <= grant_a_d;
      grant_b_q    <= grant_b_d;
      busy_q       <= busy_d;
      status_q     <= status_d;
      wd_cnt_q     <= wd_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign select         = select_q;
  assign grant_a        = grant_a_q;
  assign grant_b        = grant_b_q;
  assign busy           = busy_q;
  assign timeout_status = status_q;
  // Combinational so the pulse lands in the grant cycle that expires; it is
  // zero under reset because the state is IDLE there.
  assign timeout_pulse  = wd_fire;
  assign begin_gated_a  = transaction_begin_a & grant_a_q;
  assign begin_gated_b  = transaction_begin_b & grant_b_q;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tr_begin_a = 1'b0;
  logic tr_begin_b = 1'b0;
  logic tr_end = 1'b0;
  logic tr_clr = 1'b0;
  logic select, begin_gated_a, begin_gated_b, grant_a, grant_b, busy;
  logic timeout_pulse, timeout_status;

  int n_checks = 0;
  int n_errors = 0;

  bus_arbiter #(.TIMEOUT(TMO)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .transaction_begin_a (tr_begin_a),
    .transaction_begin_b (tr_begin_b),
    .transaction_end_y   (tr_end),
    .clear_error         (tr_clr),
    .select              (select),
    .begin_gated_a       (begin_gated_a),
    .begin_gated_b       (begin_gated_b),
    .grant_a             (grant_a),
    .grant_b             (grant_b),
    .busy                (busy),
    .timeout_pulse       (timeout_pulse),
    .timeout_status      (timeout_status)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus, whether we are in the release gap,
  // which grant cycle we are in (1 = first), who was served last.
  int m_owner;     // 0 none, 1 A, 2 B
  bit m_rel;
  int m_gcyc;
  int m_last;      // 1 A, 2 B
  bit m_sel;
  bit m_status;
  bit ev_a_end, ev_b_end;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_pulse();
    return (m_owner != 0) && (m_gcyc == TMO) && !tr_end;
  endfunction

  function automatic logic [7:0] exp_outs();
    bit ga, gb, bsy;
    ga  = (m_owner == 1);
    gb  = (m_owner == 2);
    bsy = (m_owner != 0) || m_rel;
    return {ga, gb, m_sel, bsy, tr_begin_a & ga, tr_begin_b & gb, model_pulse(), m_status};
  endfunction

  function automatic logic [7:0] dut_outs();
    return {grant_a, grant_b, select, busy, begin_gated_a, begin_gated_b,
            timeout_pulse, timeout_status};
  endfunction

  task automatic model_reset();
    m_owner = 0; m_rel = 0; m_gcyc = 0; m_last = 2; m_sel = 0; m_status = 0;
    ev_a_end = 0; ev_b_end = 0;
  endtask

  // One rising edge of the arbiter's rules, using the inputs held across it.
  task automatic model_edge();
    bit fire;
    fire     = model_pulse();
    ev_a_end = (m_owner == 1) && tr_end;
    ev_b_end = (m_owner == 2) && tr_end;
    if (fire) m_status = 1;
    else if (tr_clr) m_status = 0;
    if (m_owner != 0) begin
      if (tr_end || fire) begin
        m_owner = 0;
        m_rel   = 1;
      end else begin
        m_gcyc++;
      end
    end else if (m_rel) begin
      m_rel = 0;
    end else begin
      int win;
      win = 0;
      if (tr_begin_a && tr_begin_b) win = (m_last == 1) ? 2 : 1;
      else if (tr_begin_a) win = 1;
      else if (tr_begin_b) win = 2;
      if (win != 0) begin
        m_owner = win;
        m_last  = win;
        m_sel   = (win == 2);
        m_gcyc  = 1;
      end
    end
  endtask

  task automatic drive(input bit a, input bit b, input bit e, input bit c);
    tr_begin_a = a;
    tr_begin_b = b;
    tr_end     = e;
    tr_clr     = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_val("outs", {24'd0, dut_outs()}, {24'd0, exp_outs()});
  endtask

  // Asserts reset asynchronously (away from any edge) and releases it while
  // the clock is low.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("reset_outs", {24'd0, dut_outs()}, {24'd0, exp_outs()});
    tr_begin_a = 0; tr_begin_b = 0; tr_end = 0; tr_clr = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Requester behaviour: hold the request until completion is seen, keep it
  // 1-2 more cycles, occasionally abandon a grant.
  task automatic req_update(input bit ev, input bit granted, inout int hold,
                            inout bit post, inout logic lvl);
    if (ev) hold = $urandom_range(1, 2);
    if (hold > 0) begin
      lvl = 1'b1;
      hold--;
      post = 1'b1;
    end else if (post) begin
      lvl  = 1'b0;
      post = 1'b0;
    end else if (!lvl) begin
      lvl = ($urandom_range(0, 3) == 0);
    end else if (granted && $urandom_range(0, 31) == 0) begin
      lvl = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int a_hold, b_hold;
    bit a_post, b_post;
    logic na, nb;
    bit got_grant;

    #2;
    do_reset();

    // Single request from reset: grant after one edge, release at 6, idle at 7.
    drive(1, 0, 0, 0);
    tick();
    check_val("r31_grant_a", {31'd0, grant_a}, 32'd1);
    check_val("r31_select", {31'd0, select}, 32'd0);
    repeat (4) tick();
    drive(1, 0, 1, 0);
    tick();
    check_val("r31_release_busy", {31'd0, busy}, 32'd1);
    check_val("r31_release_grant", {31'd0, grant_a}, 32'd0);
    drive(0, 0, 0, 0);
    tick();
    check_val("r31_idle_busy", {31'd0, busy}, 32'd0);

    // Watchdog expiry on a B grant, then clear.
    do_reset();
    drive(0, 1, 0, 0);
    tick();
    check_val("r33_grant_b", {31'd0, grant_b}, 32'd1);
    check_val("r33_select", {31'd0, select}, 32'd1);
    repeat (TMO - 1) tick();
    check_val("r33_pulse", {31'd0, timeout_pulse}, 32'd1);
    tick();
    check_val("r33_grant_b_off", {31'd0, grant_b}, 32'd0);
    check_val("r33_status", {31'd0, timeout_status}, 32'd1);
    check_val("r33_pulse_off", {31'd0, timeout_pulse}, 32'd0);
    drive(0, 0, 0, 1);
    tick();
    check_val("r33_cleared", {31'd0, timeout_status}, 32'd0);
    drive(0, 0, 0, 0);

    // End on the last watchdog cycle wins over the timeout.
    do_reset();
    drive(1, 0, 0, 0);
    tick();
    repeat (TMO - 1) tick();
    drive(1, 0, 1, 0);
    check_val("r34_no_pulse", {31'd0, timeout_pulse}, 32'd0);
    tick();
    check_val("r34_release", {31'd0, busy & ~grant_a}, 32'd1);
    check_val("r34_status", {31'd0, timeout_status}, 32'd0);
    drive(0, 0, 0, 0);
    tick();

    // B rising during a grant to A stays gated off until B is granted.
    do_reset();
    drive(1, 0, 0, 0);
    tick();
    drive(1, 1, 0, 0);
    check_val("r35_gated_b", {31'd0, begin_gated_b}, 32'd0);
    check_val("r35_select", {31'd0, select}, 32'd0);
    tick();
    drive(1, 1, 1, 0);
    tick();
    drive(0, 1, 0, 0);
    tick();
    check_val("r35_select_hold", {31'd0, select}, 32'd0);
    tick();
    check_val("r35_grant_b", {31'd0, grant_b}, 32'd1);
    check_val("r35_gated_b_on", {31'd0, begin_gated_b}, 32'd1);
    check_val("r35_select_b", {31'd0, select}, 32'd1);

    // Reset mid-grant on B drops everything at once.
    check_val("r36_pre_grant_b", {31'd0, grant_b}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("r36_grant_b", {31'd0, grant_b}, 32'd0);
    check_val("r36_select", {31'd0, select}, 32'd0);
    check_val("r36_gated_b", {31'd0, begin_gated_b}, 32'd0);
    check_val("r36_pulse", {31'd0, timeout_pulse}, 32'd0);
    do_reset();

    // Continuous tie: grants alternate A, B, A, B starting with A.
    drive(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      got_grant = 0;
      for (int w = 0; w < 6 && !got_grant; w++) begin
        tick();
        got_grant = grant_a | grant_b;
      end
      check_val("r32_wait", {31'd0, got_grant}, 32'd1);
      check_val("r32_grant_a", {31'd0, grant_a}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check_val("r32_select", {31'd0, select}, (i % 2 == 0) ? 32'd0 : 32'd1);
      drive(1, 1, 1, 0);
      tick();
      drive(1, 1, 0, 0);
    end
    drive(0, 0, 0, 0);

    // Randomized traffic against the model.
    do_reset();
    a_hold = 0; b_hold = 0; a_post = 0; b_post = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        a_hold = 0; b_hold = 0; a_post = 0; b_post = 0;
        tick();
        continue;
      end
      na = tr_begin_a;
      nb = tr_begin_b;
      req_update(ev_a_end, m_owner == 1, a_hold, a_post, na);
      req_update(ev_b_end, m_owner == 2, b_hold, b_post, nb);
      drive(na, nb,
            (m_owner != 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 7) == 0),
            $urandom_range(0, 15) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
